// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - nibble-serial WIDTH-bit add/subtract sequencer
//
// Runs a WIDTH-bit add or two's-complement subtract through a 4-bit add/sub
// slice, one nibble per clock, least significant nibble first.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while idle
//   mode    0 = A+B, 1 = A-B
//   op_a    operand A, captured on acceptance
//   op_b    operand B, captured on acceptance
//   busy    high whenever the sequencer is not idle
//   done    one-cycle pulse; result/c_out/v valid from this cycle
//   result  registered sum/difference, held until the next completion
//   c_out   carry out of the MSB (subtract: 1 = no borrow)
//   v       signed overflow
module serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] acc;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice_sum;
    logic             msb_carry_in;
    logic [WIDTH-1:0] acc_next;

    // 4-bit add/sub slice. Subtraction inverts B here; the +1 comes from
    // carry being seeded with mode when the operation is accepted.
    always_comb begin
        a_nib        = a_q[4*idx +: 4];
        b_nib        = b_q[4*idx +: 4] ^ {4{mode_q}};
        slice_sum    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
        // Carry into bit 3 of this nibble; only meaningful on the last
        // nibble, where it is the carry into the operand MSB.
        msb_carry_in = a_nib[3] ^ b_nib[3] ^ slice_sum[3];
        acc_next     = acc;
        acc_next[4*idx +: 4] = slice_sum[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            acc    <= '0;
            result <= '0;
            c_out  <= 1'b0;
            v      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        mode_q <= mode;
                        idx    <= '0;
                        carry  <= mode;
                        acc    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    carry <= slice_sum[4];
                    if (idx == LAST_IDX) begin
                        // Publish everything in one edge so no partial
                        // result is ever visible.
                        result <= acc_next;
                        c_out  <= slice_sum[4];
                        v      <= msb_carry_in ^ slice_sum[4];
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pure decodes of the state register; no input reaches these outputs.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;

    localparam int N16 = 4;
    localparam int N4  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0, mode16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, c16, v16;
    logic [15:0] r16;

    logic        start4 = 1'b0, mode4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, c4, v4;
    logic [3:0]  r4;

    int tests = 0;
    int fails = 0;

    logic [17:0] q16[$];
    logic [5:0]  q4[$];

    serial_addsub_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
        .op_a(a16), .op_b(b16), .busy(busy16), .done(done16),
        .result(r16), .c_out(c16), .v(v16)
    );

    serial_addsub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4),
        .op_a(a4), .op_b(b4), .busy(busy4), .done(done4),
        .result(r4), .c_out(c4), .v(v4)
    );

    always #5 clk = ~clk;

    // Reference: whole-word add of A and (B or ~B) plus mode; overflow when
    // both addends share a sign that differs from the result sign.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [15:0] bb;
        logic [16:0] s;
        logic        ov;
        bb = m ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {16'b0, m};
        ov = (a[15] == bb[15]) && (s[15] != a[15]);
        return {s[15:0], s[16], ov};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [3:0] bb;
        logic [4:0] s;
        logic       ov;
        bb = m ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {4'b0, m};
        ov = (a[3] == bb[3]) && (s[3] != a[3]);
        return {s[3:0], s[4], ov};
    endfunction

    // Presents one request for a single cycle, then scrambles the inputs so
    // only the captured copies can produce the right answer. Returns at the
    // negedge after the accepting edge.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic m, input bit push);
        @(negedge clk);
        a16 = a; b16 = b; mode16 = m; start16 = 1'b1;
        if (push) q16.push_back(model16(a, b, m));
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom_range(0, 1));
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic m);
        @(negedge clk);
        a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
        q4.push_back(model4(a, b, m));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom_range(0, 1));
    endtask

    // Counts negedges until done is seen (lat) and busy samples on the way,
    // the done cycle included. Bounded.
    task automatic wait_done(input string name, input bit sel4, output int lat, output int bcnt, output bit ok);
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sel4 ? busy4 : busy16) bcnt++;
            if (sel4 ? done4 : done16) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s timeout: done not seen within 20 cycles", name);
        end
    endtask

    task automatic check16(input string name);
        logic [17:0] exp;
        tests++;
        if (q16.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected completion, got %h", name, {r16, c16, v16});
        end else begin
            exp = q16.pop_front();
            if ({r16, c16, v16} !== exp) begin
                fails++;
                $display("FAIL %s: got result=%h c_out=%b v=%b expected result=%h c_out=%b v=%b",
                         name, r16, c16, v16, exp[17:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic check4(input string name);
        logic [5:0] exp;
        tests++;
        if (q4.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected completion, got %h", name, {r4, c4, v4});
        end else begin
            exp = q4.pop_front();
            if ({r4, c4, v4} !== exp) begin
                fails++;
                $display("FAIL %s: got result=%h c_out=%b v=%b expected result=%h c_out=%b v=%b",
                         name, r4, c4, v4, exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b, input logic m);
        int lat, bc;
        bit ok;
        issue16(a, b, m, 1'b1);
        wait_done(name, 1'b0, lat, bc, ok);
        if (ok) check16(name);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({busy16, done16, r16, c16, v16} !== 19'b0) begin
            fails++;
            $display("FAIL reset16: got busy=%b done=%b result=%h c_out=%b v=%b expected all zero",
                     busy16, done16, r16, c16, v16);
        end
        tests++;
        if ({busy4, done4, r4, c4, v4} !== 7'b0) begin
            fails++;
            $display("FAIL reset4: got busy=%b done=%b result=%h c_out=%b v=%b expected all zero",
                     busy4, done4, r4, c4, v4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        bit ok;
        issue16(16'h1234, 16'h0FFF, 1'b0, 1'b1);
        wait_done("basic", 1'b0, lat, bc, ok);
        if (ok) begin
            check16("basic");
            // done is visible in the cycle after the last nibble edge.
            tests++;
            if (lat != N16) begin
                fails++;
                $display("FAIL basic_latency: got %0d expected %0d", lat, N16);
            end
            tests++;
            if (bc != N16 + 1) begin
                fails++;
                $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, N16 + 1);
            end
        end
        @(negedge clk);
        tests++;
        if (busy16 !== 1'b0 || done16 !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: got busy=%b done=%b expected 0 0", busy16, done16);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (r16 !== 16'h2233) begin
            fails++;
            $display("FAIL basic_hold: got %h expected 2233", r16);
        end
    endtask

    task automatic test_add_edges();
        run16("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
        run16("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    endtask

    task automatic test_sub();
        run16("sub_borrow", 16'h0005, 16'h0007, 1'b1);
        run16("sub_ovf", 16'h8000, 16'h0001, 1'b1);
        run16("sub_rand", 16'($urandom), 16'($urandom), 1'b1);
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        bit ok;
        issue16(16'h1111, 16'h2222, 1'b0, 1'b1);
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; mode16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_done("ignore_start", 1'b0, lat, bc, ok);
        if (ok) check16("ignore_start");
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy16 || done16) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignore_no_new_op: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        issue16(16'hABCD, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy16, done16, r16, c16, v16} !== 19'b0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h c_out=%b v=%b expected all zero",
                     busy16, done16, r16, c16, v16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run16("after_reset", 16'h4321, 16'h1111, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        bit ok;
        @(negedge clk);
        a16 = 16'h0F0F; b16 = 16'h00F1; mode16 = 1'b0; start16 = 1'b1;
        q16.push_back(model16(16'h0F0F, 16'h00F1, 1'b0));
        q16.push_back(model16(16'h0F0F, 16'h00F1, 1'b0));
        @(negedge clk);
        wait_done("b2b_first", 1'b0, lat, bc, ok);
        if (ok) check16("b2b_first");
        gap = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            gap++;
            if (busy16 && gap >= 2) start16 = 1'b0;
            if (done16) begin
                ok = 1'b1;
                break;
            end
        end
        start16 = 1'b0;
        tests++;
        if (!ok || gap != N16 + 2) begin
            fails++;
            $display("FAIL b2b_period: got %0d cycles (seen=%0b) expected %0d", gap, ok, N16 + 2);
        end
        if (ok) check16("b2b_second");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exhaustive4();
        int lat, bc, bad_lat;
        bit ok;
        bad_lat = 0;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    issue4(4'(a), 4'(b), 1'(m));
                    wait_done("exh4", 1'b1, lat, bc, ok);
                    if (ok) begin
                        check4("exh4");
                        if (lat != N4) bad_lat++;
                    end
                    @(negedge clk);
                end
            end
        end
        tests++;
        if (bad_lat != 0) begin
            fails++;
            $display("FAIL exh4_latency: got %0d ops with wrong latency expected 0", bad_lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_edges();
        test_sub();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive4();
        tests++;
        if (q16.size() != 0 || q4.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q16.size(), q4.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
